mm_host_master: RTL and testbench
=================================

Name: mm_host_master

Overview:
Host-side bus master for memory_manager's 8-bit byte port (data/address/wren_in). It accepts word-level read/write burst commands and splits each 16-bit word into two byte cycles: LS byte at even byte address, MS byte at odd. Read bytes are reassembled into 16-bit words. It replaces hand-driven byte sequencing at the top level and in benches. The bidirectional bus is split into out/oe/in; the tri-state sits at the top level.

Parameters:
DATA_WIDTH, 8, byte bus width
ADDRESS_WIDTH, 23, byte address width of memory_manager
CORE_WIDTH, 16, word width (= 2*DATA_WIDTH)
LEN_WIDTH, 8, burst length field width (words)
READ_LATENCY, 1, cycles from address presentation to valid bus_data_in (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when valid&ready
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDRESS_WIDTH-1  start word address
cmd_len  in  LEN_WIDTH  number of words
wr_data  in  CORE_WIDTH  write word
wr_valid  in  1  write word available
wr_ready  out  1  write word consumed when valid&ready
rd_data  out  CORE_WIDTH  read word
rd_valid  out  1  read word available, held until rd_ready
rd_ready  in  1  read consumer ready
bus_address  out  ADDRESS_WIDTH  byte address to memory_manager
bus_data_out  out  DATA_WIDTH  byte driven on write
bus_data_oe  out  1  bus drive enable
bus_data_in  in  DATA_WIDTH  byte from bus
bus_wren  out  1  to memory_manager wren_in
busy  out  1  command in progress
done  out  1  one-cycle pulse at command end

Behaviour:
- Clock is clk; reset is synchronous and active-high. Reset values: cmd_ready=0 for the reset cycle, then 1 in IDLE. wr_ready=0, rd_valid=0, rd_data=0, bus_address=0, bus_data_out=0, bus_data_oe=0, bus_wren=0, busy=0, done=0.
- States: IDLE, WR_WAIT, WR_LO, WR_HI, RD_LO, RD_HI, RD_OUT, DONE.
- IDLE: cmd_ready=1. On accept, latch cmd_write, cmd_addr, cmd_len and set busy=1 from the next cycle.
  - cmd_len=0: go to DONE with no bus activity.
  - Otherwise go to WR_WAIT for a write, RD_LO for a read.
- WR_WAIT: wr_ready=1, bus_wren=0, oe=0. On wr_valid, capture the word and go to WR_LO.
- WR_LO: exactly 1 cycle. bus_address={word,0}, bus_data_out=word[7:0], oe=1, wren=1.
- WR_HI: exactly 1 cycle. bus_address={word,1}, bus_data_out=word[15:8], oe=1, wren=1. Then decrement the count and increment the word address. Go to WR_WAIT if words remain, else DONE.
- A write word with wr_valid already high takes 3 cycles (WAIT, LO, HI). The bus is idle in WAIT.
- RD_LO and RD_HI: wren=0, oe=0. Address {word,0} or {word,1} is held for READ_LATENCY+1 cycles. bus_data_in is captured on the last edge into the low or high half. A latency counter tracks this.
- RD_OUT: rd_valid=1 and rd_data is stable. It stays until rd_ready. Then advance to RD_LO or DONE. No bus activity while stalled.
- DONE: 1 cycle. done=1, busy=0 on exit, oe=0, wren=0, cmd_ready=0. This guarantees a turnaround cycle between commands.
- Word address wraps modulo 2^(ADDRESS_WIDTH-1). The burst continues across the wrap without error.
- bus_data_oe=1 only in WR_LO/WR_HI. bus_wren equals bus_data_oe at all times.
- Reset mid-burst: all outputs return to reset values at the next edge. The partial word is discarded and no done pulse is issued.
- cmd_valid outside IDLE is ignored (cmd_ready=0).

Decomposition:
- Package mm_host_pkg: state enum, default width constants, and the helper that builds the byte address from word address plus lane bit.
- One natural sub-module: mm_lat_counter, a down-counter loaded with READ_LATENCY that flags expiry, used by RD_LO/RD_HI.
- Top level provides the tri-state: data = bus_data_oe ? bus_data_out : 'z.

Test Plan:
- Write len=1, addr=5, wr_data=16'h1234, wr_valid held high -> bus cycles (addr 10, data 34, wren 1), then (addr 11, data 12, wren 1). done pulses 1 cycle later; memory_manager stores 16'h1234.
- Write then read len=4 from addr 0 (data 0x0011, 0x0022, 0x0033, 0x0044), READ_LATENCY=1 -> rd_data sequence matches. Each read byte takes 2 cycles; there is an oe=0 gap in DONE.
- Write burst with wr_valid low for 3 cycles before word 2 -> WR_WAIT holds 3 cycles, wren=0, no extra bus writes, data correct.
- Read burst len=2 with rd_ready low 5 cycles on word 1 -> rd_valid and rd_data stable for 5 cycles, no bus reads, word 2 is fetched after the handshake.
- Write len=2 at addr 2^22-1 -> byte addresses 0x7FFFFE, 0x7FFFFF, 0x000000, 0x000001.
- Reset asserted during WR_HI of word 3 of len=8 -> next cycle IDLE, all outputs at reset values, no done; cmd_len=0 command -> done after 1 cycle, no bus activity.

Source files
------------

// File: rtl/mm_host_pkg.sv
// Shared types and defaults for the word-to-byte host bus master.
// Byte address = word address with the byte-lane bit appended as the LSB.
package mm_host_pkg;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_ADDRESS_WIDTH = 23;
  localparam int DEF_CORE_WIDTH    = 16;
  localparam int DEF_LEN_WIDTH     = 8;
  localparam int DEF_READ_LATENCY  = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_WAIT,
    S_WR_LO,
    S_WR_HI,
    S_RD_LO,
    S_RD_HI,
    S_RD_OUT,
    S_DONE
  } state_t;

  // Callers truncate the result to their own byte-address width.
  function automatic logic [31:0] byte_addr(input logic [31:0] word_addr, input logic lane);
    return (word_addr << 1) | 32'(lane);
  endfunction

endpackage

// File: rtl/mm_lat_counter.sv
// Read-latency down-counter: expires LATENCY cycles after i_en rises, then reloads.
// Holds the load value while disabled, so every read phase starts with a full count.
module mm_lat_counter #(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(LATENCY);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] r_cnt;

  assign o_expired = i_en && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= LOAD_VAL;
    end else if (!i_en || o_expired) begin
      r_cnt <= LOAD_VAL;
    end else begin
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

endmodule

// File: rtl/mm_host_master.sv
// Word-burst host master: each 16-bit word becomes two byte cycles (LS at even, MS at odd address).
// Write word takes 3 cycles (WAIT/LO/HI), read byte READ_LATENCY+1 cycles; rd_valid holds until rd_ready.
module mm_host_master
  import mm_host_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int CORE_WIDTH    = DEF_CORE_WIDTH,
  parameter int LEN_WIDTH     = DEF_LEN_WIDTH,
  parameter int READ_LATENCY  = DEF_READ_LATENCY
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDRESS_WIDTH-2:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]     cmd_len,
  input  logic [CORE_WIDTH-1:0]    wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [CORE_WIDTH-1:0]    rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [ADDRESS_WIDTH-1:0] bus_address,
  output logic [DATA_WIDTH-1:0]    bus_data_out,
  output logic                     bus_data_oe,
  input  logic [DATA_WIDTH-1:0]    bus_data_in,
  output logic                     bus_wren,
  output logic                     busy,
  output logic                     done
);

  localparam logic [ADDRESS_WIDTH-2:0] WORD_ONE = (ADDRESS_WIDTH-1)'(1);
  localparam logic [LEN_WIDTH-1:0]     LEN_ONE  = LEN_WIDTH'(1);

  state_t                   r_state;
  state_t                   w_next;
  logic [ADDRESS_WIDTH-2:0] r_word;
  logic [LEN_WIDTH-1:0]     r_count;
  logic [CORE_WIDTH-1:0]    r_wdata;
  logic [CORE_WIDTH-1:0]    r_rdata;
  logic [ADDRESS_WIDTH-1:0] w_addr_lo;
  logic [ADDRESS_WIDTH-1:0] w_addr_hi;
  logic                     w_last;
  logic                     w_rd_active;
  logic                     w_lat_expired;

  assign w_addr_lo   = ADDRESS_WIDTH'(byte_addr(32'(r_word), 1'b0));
  assign w_addr_hi   = ADDRESS_WIDTH'(byte_addr(32'(r_word), 1'b1));
  assign w_last      = (r_count == LEN_ONE);
  assign w_rd_active = (r_state == S_RD_LO) || (r_state == S_RD_HI);
  assign rd_data     = r_rdata;

  mm_lat_counter #(
    .LATENCY(READ_LATENCY)
  ) u_lat (
    .clk      (clk),
    .reset    (reset),
    .i_en     (w_rd_active),
    .o_expired(w_lat_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    cmd_ready    = 1'b0;
    wr_ready     = 1'b0;
    rd_valid     = 1'b0;
    bus_address  = '0;
    bus_data_out = '0;
    bus_data_oe  = 1'b0;
    bus_wren     = 1'b0;
    busy         = (r_state != S_IDLE);
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = !reset;
        if (cmd_valid) begin
          if (cmd_len == '0) w_next = S_DONE;
          else if (cmd_write) w_next = S_WR_WAIT;
          else w_next = S_RD_LO;
        end
      end
      S_WR_WAIT: begin
        wr_ready = 1'b1;
        if (wr_valid) w_next = S_WR_LO;
      end
      S_WR_LO: begin
        bus_address  = w_addr_lo;
        bus_data_out = r_wdata[DATA_WIDTH-1:0];
        bus_data_oe  = 1'b1;
        bus_wren     = 1'b1;
        w_next       = S_WR_HI;
      end
      S_WR_HI: begin
        bus_address  = w_addr_hi;
        bus_data_out = r_wdata[CORE_WIDTH-1:DATA_WIDTH];
        bus_data_oe  = 1'b1;
        bus_wren     = 1'b1;
        w_next       = w_last ? S_DONE : S_WR_WAIT;
      end
      S_RD_LO: begin
        bus_address = w_addr_lo;
        if (w_lat_expired) w_next = S_RD_HI;
      end
      S_RD_HI: begin
        bus_address = w_addr_hi;
        if (w_lat_expired) w_next = S_RD_OUT;
      end
      S_RD_OUT: begin
        rd_valid = 1'b1;
        if (rd_ready) w_next = w_last ? S_DONE : S_RD_LO;
      end
      S_DONE: begin
        // Forced turnaround: no command accepted, bus released.
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_word  <= '0;
      r_count <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_word  <= cmd_addr;
            r_count <= cmd_len;
          end
        end
        S_WR_WAIT: begin
          if (wr_valid) r_wdata <= wr_data;
        end
        S_WR_HI: begin
          r_count <= r_count - LEN_ONE;
          r_word  <= r_word + WORD_ONE;
        end
        S_RD_LO: begin
          if (w_lat_expired) r_rdata[DATA_WIDTH-1:0] <= bus_data_in;
        end
        S_RD_HI: begin
          if (w_lat_expired) r_rdata[CORE_WIDTH-1:DATA_WIDTH] <= bus_data_in;
        end
        S_RD_OUT: begin
          if (rd_ready) begin
            r_count <= r_count - LEN_ONE;
            r_word  <= r_word + WORD_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_host_master.sv
// Directed bench for mm_host_master with a byte-wide memory model (one-cycle registered read).
module tb_mm_host_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [21:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [22:0] bus_address;
  logic [7:0]  bus_data_out;
  logic        bus_data_oe;
  logic [7:0]  bus_data_in;
  logic        bus_wren;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mem [0:255];
  logic [30:0] wlog [$];
  logic [15:0] wq [0:7];
  logic [15:0] rq [0:7];

  always #5 clk = ~clk;

  mm_host_master dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .bus_address (bus_address),
    .bus_data_out(bus_data_out),
    .bus_data_oe (bus_data_oe),
    .bus_data_in (bus_data_in),
    .bus_wren    (bus_wren),
    .busy        (busy),
    .done        (done)
  );

  always @(posedge clk) begin
    if (bus_wren === 1'b1) begin
      mem[bus_address[7:0]] <= bus_data_out;
      wlog.push_back({bus_address, bus_data_out});
    end
    bus_data_in <= mem[bus_address[7:0]];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_write(input logic [21:0] addr, input logic [7:0] len, input int gap_idx,
                             input int gap, output int gap_bad, output bit tmo);
    int n;
    gap_bad = 0;
    tmo = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = len;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      n = 0;
      while (wr_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) tmo = 1'b1;
      if (i == gap_idx) begin
        repeat (gap) begin
          if (wr_ready !== 1'b1 || bus_wren !== 1'b0) gap_bad++;
          @(negedge clk);
        end
      end
      wr_valid = 1'b1; wr_data = wq[i];
      @(negedge clk);
      wr_valid = 1'b0;
    end
    n = 0;
    while (done !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) tmo = 1'b1;
    @(negedge clk);
  endtask

  task automatic drive_read(input logic [21:0] addr, input logic [7:0] len, input int stall_idx,
                            input int stall, output int stall_bad, output int first_lat, output bit tmo);
    int n;
    logic [22:0] held_addr;
    stall_bad = 0;
    first_lat = -1;
    tmo = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = len;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      rd_ready = 1'b0;
      n = 0;
      while (rd_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) tmo = 1'b1;
      if (i == 0) first_lat = n;
      rq[i] = rd_data;
      held_addr = bus_address;
      if (i == stall_idx) begin
        repeat (stall) begin
          if (rd_valid !== 1'b1 || rd_data !== rq[i] || bus_data_oe !== 1'b0 ||
              bus_wren !== 1'b0 || bus_address !== held_addr) stall_bad++;
          @(negedge clk);
        end
      end
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
      if (i == stall_idx && i < int'(len) - 1 && rd_valid !== 1'b0) stall_bad++;
    end
    n = 0;
    while (done !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) tmo = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); end
    checks++;
    if ({busy, done, wr_ready, rd_valid, bus_wren, bus_data_oe} !== 6'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=000000", {busy, done, wr_ready, rd_valid, bus_wren, bus_data_oe});
    end
    checks++;
    if (bus_address !== 23'd0 || bus_data_out !== 8'd0 || rd_data !== 16'd0) begin
      failures++; $display("FAIL reset_data addr=%h dout=%h rd=%h exp=0", bus_address, bus_data_out, rd_data);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL idle_cmd_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_single_write();
    wlog.delete();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 22'd5; cmd_len = 8'd1;
    wr_valid = 1'b1; wr_data = 16'h1234;
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0 || bus_wren !== 1'b0) begin
      failures++; $display("FAIL wait_state wr_ready=%b busy=%b cmd_ready=%b wren=%b exp=1 1 0 0", wr_ready, busy, cmd_ready, bus_wren);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_address !== 23'd10 || bus_data_out !== 8'h34 || bus_wren !== 1'b1 || bus_data_oe !== 1'b1) begin
      failures++; $display("FAIL wr_lo addr=%h data=%h wren=%b oe=%b exp=00000a 34 1 1", bus_address, bus_data_out, bus_wren, bus_data_oe);
    end
    wr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_address !== 23'd11 || bus_data_out !== 8'h12 || bus_wren !== 1'b1 || bus_data_oe !== 1'b1) begin
      failures++; $display("FAIL wr_hi addr=%h data=%h wren=%b oe=%b exp=00000b 12 1 1", bus_address, bus_data_out, bus_wren, bus_data_oe);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || bus_data_oe !== 1'b0 || bus_wren !== 1'b0 || cmd_ready !== 1'b0) begin
      failures++; $display("FAIL done_cycle done=%b oe=%b wren=%b cmd_ready=%b exp=1 0 0 0", done, bus_data_oe, bus_wren, cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL after_done done=%b busy=%b cmd_ready=%b exp=0 0 1", done, busy, cmd_ready);
    end
    checks++;
    if (mem[10] !== 8'h34 || mem[11] !== 8'h12 || wlog.size() != 2) begin
      failures++; $display("FAIL single_mem got=%h%h writes=%0d exp=1234 writes=2", mem[11], mem[10], wlog.size());
    end
  endtask

  task automatic test_burst_write_read();
    int  gb, sb, lat;
    bit  tmo;
    wq[0] = 16'h0011; wq[1] = 16'h0022; wq[2] = 16'h0033; wq[3] = 16'h0044;
    wlog.delete();
    drive_write(22'd0, 8'd4, -1, 0, gb, tmo);
    checks++; if (tmo || wlog.size() != 8) begin failures++; $display("FAIL burst_wr tmo=%b writes=%0d exp=0 8", tmo, wlog.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({mem[2*i+1], mem[2*i]} !== wq[i]) begin
        failures++; $display("FAIL burst_mem[%0d] got=%h exp=%h", i, {mem[2*i+1], mem[2*i]}, wq[i]);
      end
    end
    drive_read(22'd0, 8'd4, -1, 0, sb, lat, tmo);
    checks++; if (tmo || lat != 4) begin failures++; $display("FAIL burst_rd_latency tmo=%b got=%0d exp=4", tmo, lat); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rq[i] !== wq[i]) begin failures++; $display("FAIL burst_rd[%0d] got=%h exp=%h", i, rq[i], wq[i]); end
    end
  endtask

  task automatic test_write_gap();
    int  gb;
    bit  tmo;
    logic [30:0] exp_log [0:3];
    exp_log[0] = {23'h20, 8'hB2}; exp_log[1] = {23'h21, 8'hA1};
    exp_log[2] = {23'h22, 8'hD4}; exp_log[3] = {23'h23, 8'hC3};
    wq[0] = 16'hA1B2; wq[1] = 16'hC3D4;
    wlog.delete();
    drive_write(22'h10, 8'd2, 1, 3, gb, tmo);
    checks++; if (tmo || gb != 0) begin failures++; $display("FAIL gap_wait tmo=%b bad_cycles=%0d exp=0 0", tmo, gb); end
    checks++; if (wlog.size() != 4) begin failures++; $display("FAIL gap_write_count got=%0d exp=4", wlog.size()); end
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      checks++;
      if (wlog[i] !== exp_log[i]) begin failures++; $display("FAIL gap_log[%0d] got=%h exp=%h", i, wlog[i], exp_log[i]); end
    end
  endtask

  task automatic test_read_stall();
    int  sb, lat;
    bit  tmo;
    drive_read(22'h10, 8'd2, 0, 5, sb, lat, tmo);
    checks++; if (tmo || sb != 0) begin failures++; $display("FAIL stall_hold tmo=%b bad_cycles=%0d exp=0 0", tmo, sb); end
    checks++; if (rq[0] !== 16'hA1B2) begin failures++; $display("FAIL stall_rd0 got=%h exp=a1b2", rq[0]); end
    checks++; if (rq[1] !== 16'hC3D4) begin failures++; $display("FAIL stall_rd1 got=%h exp=c3d4", rq[1]); end
  endtask

  task automatic test_wrap();
    int  gb;
    bit  tmo;
    logic [30:0] exp_log [0:3];
    exp_log[0] = {23'h7FFFFE, 8'hEF}; exp_log[1] = {23'h7FFFFF, 8'hBE};
    exp_log[2] = {23'h000000, 8'hFE}; exp_log[3] = {23'h000001, 8'hCA};
    wq[0] = 16'hBEEF; wq[1] = 16'hCAFE;
    wlog.delete();
    drive_write(22'h3FFFFF, 8'd2, -1, 0, gb, tmo);
    checks++; if (tmo || wlog.size() != 4) begin failures++; $display("FAIL wrap_count tmo=%b got=%0d exp=0 4", tmo, wlog.size()); end
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      checks++;
      if (wlog[i] !== exp_log[i]) begin failures++; $display("FAIL wrap_log[%0d] got=%h exp=%h", i, wlog[i], exp_log[i]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int n;
    bit seen_done;
    wlog.delete();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 22'h20; cmd_len = 8'd8;
    wr_valid = 1'b1; wr_data = 16'hABCD;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!(bus_wren === 1'b1 && bus_address === 23'h45) && n < 60) begin @(negedge clk); n++; end
    checks++; if (n >= 60) begin failures++; $display("FAIL midrst_reach_hi3 got=timeout exp=addr 000045"); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy, done, wr_ready, rd_valid, bus_wren, bus_data_oe} !== 7'b0 ||
        bus_address !== 23'd0 || bus_data_out !== 8'd0 || rd_data !== 16'd0) begin
      failures++;
      $display("FAIL midrst_outputs flags=%b addr=%h dout=%h rd=%h exp=all zero",
               {cmd_ready, busy, done, wr_ready, rd_valid, bus_wren, bus_data_oe}, bus_address, bus_data_out, rd_data);
    end
    reset = 1'b0;
    wr_valid = 1'b0;
    checks++; if (wlog.size() != 6) begin failures++; $display("FAIL midrst_writes got=%0d exp=6", wlog.size()); end
    seen_done = 1'b0;
    repeat (5) begin @(negedge clk); if (done === 1'b1) seen_done = 1'b1; end
    checks++; if (seen_done || cmd_ready !== 1'b1) begin failures++; $display("FAIL midrst_no_done done_seen=%b cmd_ready=%b exp=0 1", seen_done, cmd_ready); end
  endtask

  task automatic test_zero_len();
    wlog.delete();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 22'h7; cmd_len = 8'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || bus_data_oe !== 1'b0 || rd_valid !== 1'b0) begin
      failures++; $display("FAIL zero_len_done done=%b busy=%b oe=%b rd_valid=%b exp=1 1 0 0", done, busy, bus_data_oe, rd_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || wlog.size() != 0) begin
      failures++; $display("FAIL zero_len_end done=%b busy=%b cmd_ready=%b writes=%0d exp=0 0 1 0", done, busy, cmd_ready, wlog.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst_write_read();
    test_write_gap();
    test_read_stall();
    test_wrap();
    test_reset_mid_burst();
    test_zero_len();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
